// File: rtl/srambank_initiator.sv
// rtl/srambank_initiator.sv - request-side controller for a group of synchronous SRAM banks
module srambank_initiator #(
   parameter int NBANKS     = 4,
   parameter int BANK_AW    = 9,
   parameter int DW         = 64,
   parameter int INIT_CLEAR = 1,
   localparam int AW        = BANK_AW + $clog2(NBANKS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [AW-1:0]        req_addr,
   input  logic [DW-1:0]        req_wdata,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DW-1:0]        rsp_data,
   output logic                 init_done,
   output logic [BANK_AW-1:0]   ADDRESS,
   output logic [DW-1:0]        wd,
   output logic [NBANKS-1:0]    banksel,
   output logic                 read,
   output logic                 write,
   input  logic [NBANKS*DW-1:0] bank_dataout
);

   localparam int BW = $clog2(NBANKS);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t            state, state_nx;
   logic [AW-1:0]     cnt;
   logic              rd_pending;
   logic [BW-1:0]     rd_bank;
   logic [BW-1:0]     req_bank;
   logic [DW-1:0]     fifo_mem [2];
   logic              wptr, rptr;
   logic [1:0]        count;
   logic [1:0]        occ;
   logic              push, pop, rd_ok, accept;
   logic [DW-1:0]     rd_word;

   assign req_bank  = req_addr[AW-1:BANK_AW];
   assign rsp_valid = (count != 2'd0);
   assign rsp_data  = fifo_mem[rptr];
   assign pop       = rsp_valid & rsp_ready;
   assign push      = rd_pending;
   assign init_done = (state == S_RUN);

   // Response credit: a slot is reserved for every read already in the bank pipe.
   assign occ   = count + {1'b0, rd_pending};
   assign rd_ok = (occ < 2'd2) | ((occ == 2'd2) & pop);

   // Select the data word of the bank that served the read one cycle ago.
   always_comb begin
      rd_word = '0;
      for (int b = 0; b < NBANKS; b++) begin
         if (rd_bank == BW'(b)) rd_word = bank_dataout[b*DW +: DW];
      end
   end

   // Next state and bank-side strobes; everything is forced idle while reset is held.
   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      accept    = 1'b0;
      banksel   = '0;
      ADDRESS   = '0;
      wd        = '0;
      read      = 1'b0;
      write     = 1'b0;
      if (!reset) begin
         case (state)
            S_INIT: begin
               write   = 1'b1;
               banksel = NBANKS'(1) << cnt[AW-1:BANK_AW];
               ADDRESS = cnt[BANK_AW-1:0];
               if (&cnt) state_nx = S_RUN;
            end
            S_RUN: begin
               req_ready = req_write | rd_ok;
               accept    = req_valid & req_ready;
               if (accept) begin
                  banksel = NBANKS'(1) << req_bank;
                  ADDRESS = req_addr[BANK_AW-1:0];
                  wd      = req_wdata;
                  write   = req_write;
                  read    = ~req_write;
               end
            end
            default: state_nx = S_INIT;
         endcase
      end
   end

   // State, clear-sweep counter and in-flight read tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= (INIT_CLEAR != 0) ? S_INIT : S_RUN;
         cnt        <= '0;
         rd_pending <= 1'b0;
         rd_bank    <= '0;
      end else begin
         state      <= state_nx;
         if (state == S_INIT) cnt <= cnt + 1'b1;
         rd_pending <= accept & ~req_write;
         if (accept & ~req_write) rd_bank <= req_bank;
      end
   end

   // Response FIFO pointers and occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= 1'b0;
         rptr  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) wptr <= ~wptr;
         if (pop)  rptr <= ~rptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end

   // Response FIFO storage; contents are meaningless while count is zero.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wptr] <= rd_word;
   end

endmodule
